// File: rtl/vga_timing_pkg.sv
// Shared VGA 640x480 timing constants and sync-lock state encoding.
// The scan generator and the sync decoder both import this package.
package vga_timing_pkg;

  localparam int unsigned VGA_H_TOTAL      = 800;
  localparam int unsigned VGA_H_SYNC       = 96;
  localparam int unsigned VGA_H_ACT_START  = 144;
  localparam int unsigned VGA_H_ACT        = 640;
  localparam int unsigned VGA_V_TOTAL      = 525;
  localparam int unsigned VGA_V_SYNC       = 2;
  localparam int unsigned VGA_V_ACT_START  = 35;
  localparam int unsigned VGA_V_ACT        = 480;
  localparam int unsigned VGA_LOCK_FRAMES  = 2;

  // Width of the horizontal and vertical position counters.
  localparam int unsigned CNT_W = 10;

  typedef enum logic [1:0] {
    SEARCH = 2'd0,
    ALIGN  = 2'd1,
    LOCKED = 2'd2
  } sync_state_e;

endpackage

// File: rtl/vga_period_counter.sv
// Falling-edge detector on an active-low sync input plus a saturating
// position counter. Flags a period mismatch when the counter restarts and,
// optionally, a timeout when the expected period elapses with no restart.
module vga_period_counter #(
  parameter int unsigned W          = 10,
  parameter int unsigned PERIOD     = 800,
  parameter int unsigned SAT_MAX    = 800,
  parameter bit          TIMEOUT_EN = 1'b1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         sync_in,
  input  logic         tick,
  input  logic         qual,
  input  logic         restart,
  output logic         fall,
  output logic [W-1:0] pos,
  output logic         per_err,
  output logic         lost_err
);

  localparam logic [W-1:0] PER = W'(PERIOD);
  localparam logic [W-1:0] SAT = W'(SAT_MAX);

  logic         sync_q, sync_d;
  logic         armed_q, armed_d;
  logic [W-1:0] cnt_q, cnt_d;
  logic [W-1:0] nxt;
  logic         zero;

  // Edge detection, current position and error flags for this sample.
  always_comb begin
    fall = sync_q & ~sync_in;
    zero = fall & qual;
    nxt  = cnt_q;
    if (tick && (cnt_q != SAT)) begin
      nxt = cnt_q + 1'b1;
    end
    pos      = zero ? '0 : nxt;
    per_err  = zero && armed_q && (nxt != PER);
    // Fires only on the sample that reaches PERIOD; saturation keeps it single.
    lost_err = TIMEOUT_EN && !zero && (nxt == PER) && (cnt_q != PER);
  end

  // Next-state for the counter, the previous-sample register and the arm flag.
  // Kept apart from the error logic so restart never loops back into per_err.
  always_comb begin
    sync_d  = sync_in;
    cnt_d   = pos;
    armed_d = armed_q;
    if (zero) begin
      armed_d = 1'b1;
    end else if (restart) begin
      armed_d = 1'b0;
    end
  end

  // Counter state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q  <= 1'b1;
      cnt_q   <= '0;
      armed_q <= 1'b0;
    end else begin
      sync_q  <= sync_d;
      cnt_q   <= cnt_d;
      armed_q <= armed_d;
    end
  end

endmodule

// File: rtl/vga_sync_decoder.sv
// Receive-side VGA sync decoder: recovers pixel coordinates from hsync/vsync,
// checks line/frame timing, locks after consecutive good frames and emits a
// per-pixel valid stream with framebuffer addresses.
module vga_sync_decoder
  import vga_timing_pkg::*;
#(
  parameter int unsigned H_TOTAL     = VGA_H_TOTAL,
  parameter int unsigned H_ACT_START = VGA_H_ACT_START,
  parameter int unsigned H_ACT       = VGA_H_ACT,
  parameter int unsigned V_TOTAL     = VGA_V_TOTAL,
  parameter int unsigned V_ACT_START = VGA_V_ACT_START,
  parameter int unsigned V_ACT       = VGA_V_ACT,
  parameter int unsigned LOCK_FRAMES = VGA_LOCK_FRAMES
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        hsync,
  input  logic        vsync,
  input  logic [11:0] videoIn,
  output logic [9:0]  HAddr,
  output logic [8:0]  VAddr,
  output logic        pixValid,
  output logic [11:0] pixData,
  output logic        frameStart,
  output logic        locked,
  output logic        syncErr
);

  localparam int unsigned       GW     = $clog2(LOCK_FRAMES + 1);
  localparam logic [GW-1:0]     LOCK_N = GW'(LOCK_FRAMES);
  localparam logic [CNT_W-1:0]  H_LO   = CNT_W'(H_ACT_START);
  localparam logic [CNT_W-1:0]  H_HI   = CNT_W'(H_ACT_START + H_ACT);
  localparam logic [CNT_W-1:0]  V_LO   = CNT_W'(V_ACT_START);
  localparam logic [CNT_W-1:0]  V_HI   = CNT_W'(V_ACT_START + V_ACT);

  logic             hfall, vfall, coincident, violation, active;
  logic [CNT_W-1:0] p, l;
  logic             h_per_err, h_lost, v_per_err, v_lost;
  logic             restart_h, restart_v;

  sync_state_e      state_q, state_d;
  logic [GW-1:0]    good_q, good_d, good_inc;
  logic [9:0]       haddr_q, haddr_d;
  logic [8:0]       vaddr_q, vaddr_d;
  logic             pix_valid_q, pix_valid_d;
  logic [11:0]      pix_data_q, pix_data_d;
  logic             frame_start_q, frame_start_d;
  logic             locked_q, locked_d;
  logic             sync_err_q, sync_err_d;

  vga_period_counter #(
    .W          (CNT_W),
    .PERIOD     (H_TOTAL),
    .SAT_MAX    (H_TOTAL),
    .TIMEOUT_EN (1'b1)
  ) u_hcnt (
    .clk      (clk),
    .rst_n    (rst_n),
    .sync_in  (hsync),
    .tick     (1'b1),
    .qual     (1'b1),
    .restart  (restart_h),
    .fall     (hfall),
    .pos      (p),
    .per_err  (h_per_err),
    .lost_err (h_lost)
  );

  vga_period_counter #(
    .W          (CNT_W),
    .PERIOD     (V_TOTAL),
    .SAT_MAX    ((1 << CNT_W) - 1),
    .TIMEOUT_EN (1'b0)
  ) u_lcnt (
    .clk      (clk),
    .rst_n    (rst_n),
    .sync_in  (vsync),
    .tick     (hfall),
    .qual     (hfall),
    .restart  (restart_v),
    .fall     (vfall),
    .pos      (l),
    .per_err  (v_per_err),
    .lost_err (v_lost)
  );

  // Lock state machine: any violation wins over a lock-completing frame edge.
  always_comb begin
    coincident = hfall & vfall;
    violation  = h_per_err | h_lost | v_per_err | v_lost | (vfall & ~hfall);
    state_d    = state_q;
    good_d     = good_q;
    good_inc   = good_q + 1'b1;
    case (state_q)
      SEARCH: begin
        if (coincident && !violation) begin
          state_d = ALIGN;
          good_d  = '0;
        end
      end
      ALIGN: begin
        if (violation) begin
          state_d = SEARCH;
        end else if (coincident) begin
          good_d = good_inc;
          if (good_inc >= LOCK_N) begin
            state_d = LOCKED;
          end
        end
      end
      LOCKED: begin
        if (violation) begin
          state_d = SEARCH;
        end
      end
      default: state_d = SEARCH;
    endcase
  end

  // The line check is unarmed once per SEARCH entry; the frame check stays
  // unarmed for all of SEARCH so only ALIGN/LOCKED frames are length-checked.
  always_comb begin
    restart_h = (state_q != SEARCH) && (state_d == SEARCH);
    restart_v = (state_q == SEARCH);
  end

  // Capture path and status pulses, all registered one cycle after the sample.
  always_comb begin
    active        = (p >= H_LO) && (p < H_HI) && (l >= V_LO) && (l < V_HI);
    pix_valid_d   = active && (state_q == LOCKED);
    pix_data_d    = pix_valid_d ? videoIn : '0;
    haddr_d       = pix_valid_d ? (p - H_LO) : haddr_q;
    vaddr_d       = pix_valid_d ? 9'(l - V_LO) : vaddr_q;
    frame_start_d = coincident;
    sync_err_d    = violation;
    locked_d      = (state_d == LOCKED);
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= SEARCH;
      good_q        <= '0;
      haddr_q       <= '0;
      vaddr_q       <= '0;
      pix_valid_q   <= 1'b0;
      pix_data_q    <= '0;
      frame_start_q <= 1'b0;
      locked_q      <= 1'b0;
      sync_err_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      good_q        <= good_d;
      haddr_q       <= haddr_d;
      vaddr_q       <= vaddr_d;
      pix_valid_q   <= pix_valid_d;
      pix_data_q    <= pix_data_d;
      frame_start_q <= frame_start_d;
      locked_q      <= locked_d;
      sync_err_q    <= sync_err_d;
    end
  end

  assign HAddr      = haddr_q;
  assign VAddr      = vaddr_q;
  assign pixValid   = pix_valid_q;
  assign pixData    = pix_data_q;
  assign frameStart = frame_start_q;
  assign locked     = locked_q;
  assign syncErr    = sync_err_q;

endmodule
